// File: rtl/bitwise_logic_unit_pkg.sv
// rtl/bitwise_logic_unit_pkg.sv - op encoding and per-lane fold for the bitwise logic unit
package blu_pkg;

    typedef enum logic [1:0] {
        BLU_AND  = 2'b00,
        BLU_OR   = 2'b01,
        BLU_XOR  = 2'b10,
        BLU_NAND = 2'b11
    } blu_op_e;

    // Upper bound on NUM_IN; one fold call handles one bit position across all operands.
    localparam int BLU_MAX_IN = 32;

    function automatic logic blu_fold(input blu_op_e op,
                                      input logic [BLU_MAX_IN-1:0] operands,
                                      input int num_in);
        logic and_r;
        logic or_r;
        logic xor_r;
        logic res;
        and_r = 1'b1;
        or_r  = 1'b0;
        xor_r = 1'b0;
        for (int k = 0; k < BLU_MAX_IN; k++) begin
            if (k < num_in) begin
                and_r = and_r & operands[k];
                or_r  = or_r | operands[k];
                xor_r = xor_r ^ operands[k];
            end
        end
        case (op)
            BLU_AND: res = and_r;
            BLU_OR:  res = or_r;
            BLU_XOR: res = xor_r;
            default: res = ~and_r;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// rtl/bitwise_logic_unit_if.sv - operand/result handshake bundle for the bitwise logic unit
interface bitwise_logic_unit_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_op;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_zero;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/bitwise_logic_unit_skid_buf.sv
// rtl/bitwise_logic_unit_skid_buf.sv - 2-entry valid/ready skid stage (output reg + skid entry)
module blu_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_d;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_d;
    logic             accept;
    logic             out_free;

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_comb begin
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        if (out_free) begin
            if (skid_valid) begin
                // Oldest word lives in the skid; it must reach the output first.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data;
                skid_valid_d = accept;
                skid_data_d  = accept ? in_data : skid_data;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            in_ready   <= ~skid_valid_d;
        end
    end
endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - pipelined N-operand AND/OR/XOR/NAND unit; BLU_STATS_EN adds tx_count
module bitwise_logic_unit
    import blu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    bitwise_logic_unit_if.slave bus
`ifdef BLU_STATS_EN
    ,
    output logic [31:0]         tx_count
`endif
);
    logic [WIDTH-1:0]      fold_data;
    logic [BLU_MAX_IN-1:0] lane;

    // Gather bit b of every operand into one lane and fold it.
    always_comb begin
        fold_data = '0;
        lane      = '0;
        for (int b = 0; b < WIDTH; b++) begin
            lane = '0;
            for (int k = 0; k < NUM_IN; k++) begin
                lane[k] = bus.in_data[k*WIDTH + b];
            end
            fold_data[b] = blu_fold(blu_op_e'(bus.in_op), lane, NUM_IN);
        end
    end

    blu_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (fold_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data)
    );

    assign bus.out_zero = (bus.out_data == '0);

`ifdef BLU_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_count <= '0;
        end else if (bus.out_valid && bus.out_ready && (tx_count != 32'hFFFF_FFFF)) begin
            tx_count <= tx_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - self-checking bench: directed steps plus random traffic vs a FIFO reference
module tb_bitwise_logic_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   hs_count;
    bit   rand_ready;
    logic [7:0] sb[$];
`ifdef BLU_STATS_EN
    logic [31:0] tx_count;
`endif

    bitwise_logic_unit_if #(.WIDTH(8), .NUM_IN(4)) bus ();

    bitwise_logic_unit #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef BLU_STATS_EN
        ,
        .tx_count (tx_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count ones per bit column across the four operands.
    function automatic logic [7:0] ref_fold(input int op, input logic [31:0] d);
        logic [7:0] r;
        int cnt;
        for (int b = 0; b < 8; b++) begin
            cnt = 0;
            for (int k = 0; k < 4; k++) cnt += int'(d[k*8 + b]);
            case (op)
                0:       r[b] = (cnt == 4);
                1:       r[b] = (cnt != 0);
                2:       r[b] = (cnt % 2 == 1);
                default: r[b] = (cnt != 4);
            endcase
        end
        return r;
    endfunction

    // Scoreboard: handshakes are resolved at the next rising edge, so look at the negedge before it.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!rst_n) begin
            sb.delete();
            hs_count = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("out_has_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(exp_w));
                    check("out_zero", 32'(bus.out_zero), 32'(exp_w == 8'h00));
                end
                hs_count++;
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(ref_fold(int'(bus.in_op), bus.in_data));
        end
    end

    task automatic step();
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        check("send_accept", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        while (bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_idle", 32'(bus.out_valid), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] tt_exp;
        logic [7:0] t2_exp[4];
        logic       a;
        logic       b;
        tests = 0;
        fails = 0;
        hs_count = 0;
        rand_ready = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 2'b00;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        tt_exp = 4'b1000;
        t2_exp = '{8'h80, 8'hFF, 8'h69, 8'h7F};

        // Reset state
        repeat (2) begin @(posedge clk); #1; end
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd1);
`ifdef BLU_STATS_EN
        check("rst_tx_count", tx_count, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Truth table of AND on bit 0; other operands all ones, 1-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 1'(i >> 1);
            b = 1'(i);
            send(2'b00, {8'hFF, 8'hFF, 7'b0, b, 7'b0, a});
            check("tt_valid", 32'(bus.out_valid), 32'd1);
            check("tt_data", 32'(bus.out_data), 32'(tt_exp[i]));
        end

        // Four operands {F0,CC,AA,FF} under each op
        for (int op = 0; op < 4; op++) begin
            send(2'(op), 32'hFFAACCF0);
            check("op4_data", 32'(bus.out_data), 32'(t2_exp[op]));
            check("op4_zero", 32'(bus.out_zero), 32'd0);
        end

        // XOR of equal words yields zero
        send(2'b10, 32'h0000_5555);
        check("xor_zero_data", 32'(bus.out_data), 32'd0);
        check("xor_zero_flag", 32'(bus.out_zero), 32'd1);
        drain();

        // Backpressure: A to output, B to skid, C held off
        bus.out_ready = 1'b0;
        send(2'b01, 32'h0000_0011);
        check("bp_ready_after_a", 32'(bus.in_ready), 32'd1);
        send(2'b01, 32'h0000_0022);
        check("bp_ready_after_b", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b01;
        bus.in_data  = 32'h0000_0033;
        repeat (3) begin @(posedge clk); #1; end
        check("bp_c_held", 32'(bus.in_ready), 32'd0);
        check("bp_out_held", 32'(bus.out_data), 32'h11);
        check("bp_sb_depth", 32'(sb.size()), 32'd2);
        bus.out_ready = 1'b1;
        send(2'b01, 32'h0000_0033);
        drain();

        // Reset with two words held
        bus.out_ready = 1'b0;
        send(2'b10, 32'h0000_00F0);
        send(2'b10, 32'h0000_000F);
        check("rs_full", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rs_nothing_emerges", 32'(bus.out_valid), 32'd0);
        end
        check("rs_in_ready_back", 32'(bus.in_ready), 32'd1);
`ifdef BLU_STATS_EN
        check("rs_tx_count", tx_count, 32'd0);

        // Ten handshakes with out_ready toggling
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(2'(i % 4), $urandom);
        drain();
        check("stats_ten", tx_count, 32'd10);
`endif

        // Random traffic with random backpressure and idle gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();
`ifdef BLU_STATS_EN
        check("stats_total", tx_count, 32'(hs_count));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
